// File: rtl/bus_pkg.sv
// Shared definitions for the bus requester slice.
// - state_t     : requester FSM encoding
// - DEF_*       : default parameter values
// - word_width  : width of one buffered word, laid out as {last, data},
//                 so the last flag sits at bit DATA_WIDTH.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_FIFO_DEPTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    function automatic int word_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/bus_tx_fifo.sv
// Synchronous transmit FIFO for the bus requester.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (flushes pointers)
//   wr_en, wr_data  : push a word (ignored while full)
//   rd_en           : pop the head word (ignored while empty)
//   full, empty     : occupancy flags
//   rd_data         : current head word (valid when !empty)
module bus_tx_fifo
    import bus_pkg::*;
#(
    parameter int WIDTH = word_width(DEF_DATA_WIDTH),
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bus_requester.sv
// Requester side of the shared-bus priority arbiter. Buffers client packets,
// raises req, streams exactly one packet per grant, then waits for the grant
// to clear before requesting again.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   in_data, in_last, in_valid      : client word stream
//   in_ready                        : buffer not full
//   req, grant                      : arbiter handshake (grant is latched)
//   bus_data, bus_last, bus_valid   : FIFO head onto the shared bus
//   bus_ready                       : bus sink accepts the word
//   timeout                         : one-cycle pulse on request starvation
//   busy                            : FSM not idle
module bus_requester
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  req,
    input  logic                  grant,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_last,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  timeout,
    output logic                  busy
);

    localparam int WW = word_width(DATA_WIDTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_pkt_cnt;
    logic [TW-1:0]         r_wait;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_timeout_hit;
    logic [WW-1:0]         w_head;
    logic                  w_head_last;
    logic [DATA_WIDTH-1:0] w_head_data;

    bus_tx_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr),
        .wr_data ({in_last, in_data}),
        .rd_en   (w_pop),
        .full    (w_full),
        .empty   (w_empty),
        .rd_data (w_head)
    );

    assign {w_head_last, w_head_data} = w_head;

    assign in_ready = !w_full;
    assign bus_data = w_head_data;
    assign bus_last = w_head_last;
    assign w_wr     = in_valid && !w_full;
    assign w_pop    = bus_valid && bus_ready;
    assign w_inc    = w_wr && in_last;
    assign w_dec    = w_pop && w_head_last;

    // r_wait holds the number of REQ cycles already elapsed, so the pulse
    // lands on the TIMEOUT_CYCLES-th REQ cycle and then every period after.
    assign w_timeout_hit = (r_state == ST_REQ) &&
                           (r_wait == TW'(TIMEOUT_CYCLES - 1));

    // Complete packets held in the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else begin
            case ({w_inc, w_dec})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + CW'(1);
                2'b01:   r_pkt_cnt <= r_pkt_cnt - CW'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != ST_REQ || w_timeout_hit) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req         = 1'b0;
        bus_valid   = 1'b0;
        timeout     = w_timeout_hit;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // A full buffer with no complete packet means an oversized
                // packet: request anyway and stream it cut-through.
                if (r_pkt_cnt != '0 || w_full) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                req = 1'b1;
                if (grant) w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                req       = 1'b1;
                bus_valid = grant && !w_empty;
                if (w_dec) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Hold off until the arbiter's latched grant clears.
                if (!grant) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester. Instance A (depth 16, timeout 4) covers
// reset, single packet, backpressure/grant loss, stale grant, timeout and
// mid-transfer reset; instance B (depth 4) covers the oversized packet.
module tb_bus_requester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       bus_ready = 1'b0;

    logic       in_valid_a = 1'b0, grant_a = 1'b0;
    logic       in_ready_a, req_a, bus_last_a, bus_valid_a, timeout_a, busy_a;
    logic [7:0] bus_data_a;

    logic       in_valid_b = 1'b0, grant_b = 1'b0;
    logic       in_ready_b, req_b, bus_last_b, bus_valid_b, timeout_b, busy_b;
    logic [7:0] bus_data_b;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] mon_a[$];
    logic [8:0] mon_b[$];

    bus_requester #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .req(req_a), .grant(grant_a),
        .bus_data(bus_data_a), .bus_last(bus_last_a), .bus_valid(bus_valid_a), .bus_ready(bus_ready),
        .timeout(timeout_a), .busy(busy_a)
    );

    bus_requester #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .req(req_b), .grant(grant_b),
        .bus_data(bus_data_b), .bus_last(bus_last_b), .bus_valid(bus_valid_b), .bus_ready(bus_ready),
        .timeout(timeout_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge sees what the next
    // posedge will act on.
    always @(negedge clk) begin
        if (bus_valid_a && bus_ready) mon_a.push_back({bus_last_a, bus_data_a});
        if (bus_valid_b && bus_ready) mon_b.push_back({bus_last_b, bus_data_b});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input logic [7:0] d, input logic l);
        in_valid_a = 1'b1;
        in_data    = d;
        in_last    = l;
        step();
        in_valid_a = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic wait_req_a(input string tag);
        for (int i = 0; i < 20 && req_a !== 1'b1; i++) step();
        chk(tag, req_a, 1);
    endtask

    task automatic drain_a(input int n, input string tag);
        for (int i = 0; i < 40 && mon_a.size() < n; i++) step();
        chk(tag, mon_a.size(), n);
    endtask

    task automatic release_a(input string tag);
        grant_a = 1'b0;
        for (int i = 0; i < 10 && busy_a !== 1'b0; i++) step();
        chk(tag, busy_a, 0);
    endtask

    initial begin
        int  idx;
        int  base;
        logic acc, saw_full, saw_early_req, saw_both, saw_to_b;

        // ---- reset state ----
        step(); step(); step();
        rst = 1'b0;
        #1;
        chk("rst_req", req_a, 0);
        chk("rst_bus_valid", bus_valid_a, 0);
        chk("rst_timeout", timeout_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_in_ready_b", in_ready_b, 1);

        // ---- single packet, grant 2 cycles after req ----
        put_a(8'h11, 1'b0); put_a(8'h22, 1'b0); put_a(8'h33, 1'b1);
        bus_ready = 1'b1;
        wait_req_a("sp_req");
        step(); step();
        grant_a = 1'b1;
        #1;
        chk("sp_grant_cycle_valid", bus_valid_a, 0);
        step();
        chk("sp_w0_valid", bus_valid_a, 1);
        chk("sp_w0", {bus_last_a, bus_data_a}, 9'h011);
        step();
        chk("sp_w1", {bus_last_a, bus_data_a}, 9'h022);
        step();
        chk("sp_w2", {bus_last_a, bus_data_a}, 9'h133);
        step();
        chk("sp_req_drop", req_a, 0);
        chk("sp_rel_valid", bus_valid_a, 0);
        chk("sp_rel_busy", busy_a, 1);
        grant_a = 1'b0;
        step();
        chk("sp_busy_clear", busy_a, 0);
        chk("sp_count", mon_a.size(), 3);
        chk("sp_m0", mon_a[0], 9'h011);
        chk("sp_m1", mon_a[1], 9'h022);
        chk("sp_m2", mon_a[2], 9'h133);
        mon_a.delete();

        // ---- backpressure then grant loss ----
        bus_ready = 1'b0;
        put_a(8'hA0, 1'b0); put_a(8'hA1, 1'b0); put_a(8'hA2, 1'b0); put_a(8'hA3, 1'b1);
        wait_req_a("bp_req");
        grant_a = 1'b1;
        step();
        chk("bp_valid", bus_valid_a, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_stall_data", {bus_last_a, bus_data_a}, 9'h0A0);
            chk("bp_stall_nopop", mon_a.size(), 0);
        end
        grant_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("gl_valid_off", bus_valid_a, 0);
            chk("gl_req_held", req_a, 1);
            step();
        end
        grant_a   = 1'b1;
        bus_ready = 1'b1;
        drain_a(4, "bp_count");
        for (int i = 0; i < 4; i++)
            chk("bp_word", mon_a[i], {(i == 3) ? 1'b1 : 1'b0, 8'(8'hA0 + i)});
        release_a("bp_release");
        mon_a.delete();

        // ---- two packets, stale grant ----
        put_a(8'hB1, 1'b0); put_a(8'hB2, 1'b1); put_a(8'hC1, 1'b1);
        wait_req_a("sg_req");
        grant_a = 1'b1;
        drain_a(2, "sg_a_count");
        for (int i = 0; i < 3; i++) begin
            chk("sg_stale_req", req_a, 0);
            chk("sg_stale_valid", bus_valid_a, 0);
            chk("sg_stale_busy", busy_a, 1);
            step();
        end
        chk("sg_b_not_sent", mon_a.size(), 2);
        grant_a = 1'b0;
        step();
        chk("sg_idle", busy_a, 0);
        step();
        chk("sg_rereq", req_a, 1);
        grant_a = 1'b1;
        drain_a(3, "sg_b_count");
        chk("sg_a0", mon_a[0], 9'h0B1);
        chk("sg_a1", mon_a[1], 9'h1B2);
        chk("sg_b0", mon_a[2], 9'h1C1);
        release_a("sg_release");
        mon_a.delete();

        // ---- timeout, then reset mid-transfer with 5 words buffered ----
        bus_ready = 1'b0;
        put_a(8'hE0, 1'b0); put_a(8'hE1, 1'b0); put_a(8'hE2, 1'b0);
        put_a(8'hE3, 1'b0); put_a(8'hE4, 1'b1);
        wait_req_a("to_req");
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("to_pulse_c%0d", c), timeout_a, (c == 4 || c == 8) ? 1 : 0);
            chk("to_req_held", req_a, 1);
            step();
        end
        grant_a = 1'b1;
        step();
        chk("rx_xfer_valid", bus_valid_a, 1);
        chk("rx_xfer_head", {bus_last_a, bus_data_a}, 9'h0E0);
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        #1;
        chk("rx_req", req_a, 0);
        chk("rx_bus_valid", bus_valid_a, 0);
        chk("rx_busy", busy_a, 0);
        chk("rx_in_ready", in_ready_a, 1);
        bus_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rx_stay_idle", busy_a, 0);
        end
        chk("rx_no_words", mon_a.size(), 0);
        grant_a = 1'b0;

        // ---- oversized packet on the depth-4 instance ----
        idx = 0;
        saw_full = 1'b0; saw_early_req = 1'b0; saw_both = 1'b0; saw_to_b = 1'b0;
        for (int c = 0; c < 60 && mon_b.size() < 6; c++) begin
            in_valid_b = (idx < 6);
            in_data    = 8'(8'hD0 + idx);
            in_last    = (idx == 5);
            grant_b    = req_b;
            #1;
            if (idx == 4 && mon_b.size() == 0 && !in_ready_b) saw_full = 1'b1;
            if (req_b && idx < 6) saw_early_req = 1'b1;
            if (timeout_b) saw_to_b = 1'b1;
            acc = in_valid_b && in_ready_b;
            if (acc && bus_valid_b && bus_ready) saw_both = 1'b1;
            step();
            if (acc) idx++;
        end
        in_valid_b = 1'b0;
        in_last    = 1'b0;
        chk("ov_full_at_4", saw_full, 1);
        chk("ov_req_before_last", saw_early_req, 1);
        chk("ov_simul_wr_pop", saw_both, 1);
        chk("ov_no_timeout", saw_to_b, 0);
        chk("ov_written", idx, 6);
        chk("ov_count", mon_b.size(), 6);
        base = 0;
        for (int i = 0; i < 6; i++)
            chk("ov_word", mon_b[i], {(i == 5) ? 1'b1 : 1'b0, 8'(8'hD0 + i)});
        grant_b = 1'b0;
        for (int i = 0; i < 10 && busy_b !== 1'b0; i++) step();
        chk("ov_release", busy_b, base[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_requester.md
Name: bus_requester

Overview:
- Requester-side counterpart to the shared-bus priority arbiter.
- Buffers outgoing packets from a local client in a small FIFO and raises one request line toward the arbiter.
- On seeing its grant bit, streams one whole packet onto the shared bus, then drops the request and waits for the grant to clear before it can request again.
- One instance per bus master; its req output feeds one bit of the arbiter request vector, and the matching grant bit returns to it.

Parameters:
- DATA_WIDTH, 8, width of client and bus data words
- FIFO_DEPTH, 16, word capacity of the transmit buffer (power of two, ≥2)
- TIMEOUT_CYCLES, 255, cycles in REQ without a grant before the timeout pulse fires (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_data  in  DATA_WIDTH  client word
- in_last  in  1  marks final word of a client packet
- in_valid  in  1  client word valid
- in_ready  out  1  buffer can accept a word; equals !fifo_full
- req  out  1  request to arbiter
- grant  in  1  this requester's latched grant bit from the arbiter
- bus_data  out  DATA_WIDTH  FIFO head word
- bus_last  out  1  FIFO head is a last word
- bus_valid  out  1  word on bus valid
- bus_ready  in  1  bus sink accepts word
- timeout  out  1  one-cycle pulse on request starvation
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; FIFO flushed; pkt_count=0; wait counter=0. Outputs: req=0, bus_valid=0, timeout=0, busy=0; in_ready=1 the cycle after reset. Reset mid-transfer abandons the packet and clears the buffer; no partial-packet recovery.
- FIFO: stores {last, data}.
  - Write when in_valid && in_ready.
  - Pop when bus_valid && bus_ready.
  - Simultaneous write and pop at full or empty is legal; occupancy stays correct.
- pkt_count: +1 on a write with in_last; −1 on a pop with last. Both in one cycle → unchanged. Width clog2(FIFO_DEPTH)+1.
- State machine:
  - IDLE: move to REQ when pkt_count>0, or when FIFO is full (cut-through for oversized packets). req=0.
  - REQ: req=1. When grant=1, go to XFER next cycle; no bus_valid in the grant-seen cycle (1-cycle latency). Wait counter increments each REQ cycle. When it reaches TIMEOUT_CYCLES, timeout pulses for one cycle, the counter clears, and the block stays in REQ.
  - XFER: req=1.
    - bus_valid = grant && !fifo_empty (combinational).
    - FIFO empty mid-packet (cut-through): bus_valid=0 bubbles; ownership held.
    - grant drops mid-packet: bus_valid gated off at once; stay in XFER with req=1 and resume when grant returns.
    - Pop of a last word: go to RELEASE.
  - RELEASE: req=0, bus_valid=0. Go to IDLE when grant=0. This prevents a stale latched grant from starting the next packet.
- Exactly one packet per grant; back-to-back packets always pass through RELEASE and IDLE.
- bus_data and bus_last always present the FIFO head; they are don't-care when bus_valid=0.

Decomposition:
- Shared package bus_pkg:
  - state encoding: IDLE=2'd0, REQ=2'd1, XFER=2'd2, RELEASE=2'd3
  - default DATA_WIDTH, FIFO_DEPTH, TIMEOUT_CYCLES
  - the {last,data} word layout
- One sub-module: bus_tx_fifo, a synchronous FIFO.
  - Parameters: WIDTH=DATA_WIDTH+1, DEPTH.
  - Outputs: full, empty, head data.
- The FSM, packet counter and timeout counter live in bus_requester.

Test Plan:
- Reset: hold rst 3 cycles mid-XFER with 5 words buffered → req=0, bus_valid=0, busy=0, in_ready=1 next cycle; pkt_count=0; no bus words afterward.
- Single packet: write 3 words (0x11,0x22,0x33 with last on the third); model the arbiter asserting grant 2 cycles after req → bus_valid on the cycle after grant; words appear in order with bus_last on 0x33; req drops the cycle after the last pop; busy clears once grant=0.
- Backpressure and grant loss: in XFER, hold bus_ready=0 for 4 cycles, then drop grant for 2 cycles → bus_data stable and no pops during stall; bus_valid=0 while grant=0; transfer resumes with no loss or duplication.
- Two packets with stale grant: buffer packets A (2 words) and B (1 word); keep grant high after A ends → state stays RELEASE, B not sent; clear grant → IDLE→REQ, B sent on the next grant.
- Timeout: TIMEOUT_CYCLES=4, packet buffered, grant held 0 for 10 cycles → timeout pulses on cycles 4 and 8 after entering REQ; req stays high throughout.
- Oversized packet: FIFO_DEPTH=4; write 6 words with last on the 6th → in_ready=0 at 4 words; requester enters REQ with pkt_count=0; after grant all 6 words leave in order; simultaneous write/pop occurs with no overflow.
